// File: rtl/demux_1_4_buf.sv
// 1-to-4 buffered distributor: one valid/ready producer stream routed by SEL into four 2-entry FIFOs.
// Optional build macro DEMUX_BCAST_EN adds a bcast input that pushes one word into all four channels.
module demux_1_4_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef DEMUX_BCAST_EN
    input  logic         bcast,
`endif
    input  logic [N-1:0] X,
    input  logic [1:0]   SEL,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] C,
    output logic [N-1:0] D,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [1:0]   cnt_A,
    output logic [1:0]   cnt_B,
    output logic [1:0]   cnt_C,
    output logic [1:0]   cnt_D
);

    logic [N-1:0] mem [4][2];
    logic [N-1:0] head [4];
    logic [1:0]   cnt [4];
    logic [3:0]   wptr;
    logic [3:0]   rptr;
    logic [3:0]   push;
    logic [3:0]   pop;
    logic         bcast_on;
    logic         accept;

`ifdef DEMUX_BCAST_EN
    assign bcast_on = bcast;
`else
    assign bcast_on = 1'b0;
`endif

    // Ready looks only at registered occupancy and SEL, never at out_ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_ready = 1'b0;
        if (!rst) begin
            if (bcast_on) begin
                in_ready = (cnt[0] < 2'd2) && (cnt[1] < 2'd2) &&
                           (cnt[2] < 2'd2) && (cnt[3] < 2'd2);
            end else begin
                in_ready = (cnt[SEL] < 2'd2);
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        push      = '0;
        pop       = '0;
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            push[k]      = accept && (bcast_on || (SEL == 2'(k)));
            out_valid[k] = (cnt[k] != 2'd0);
            pop[k]       = out_valid[k] && out_ready[k];
            head[k]      = out_valid[k] ? mem[k][rptr[k]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) wptr[k] <= ~wptr[k];
                if (pop[k])  rptr[k] <= ~rptr[k];
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 2'd1;
                    2'b01:   cnt[k] <= cnt[k] - 2'd1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    // NOTE: storage is left unreset; empty channels mask their data output to zero,
    // so stale entries are never observable.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) mem[k][wptr[k]] <= X;
        end
    end

    assign A     = head[0];
    assign B     = head[1];
    assign C     = head[2];
    assign D     = head[3];
    assign cnt_A = cnt[0];
    assign cnt_B = cnt[1];
    assign cnt_C = cnt[2];
    assign cnt_D = cnt[3];

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Self-checking bench for demux_1_4_buf: directed vector table plus hand-written corner sequences.
// Covers the bcast path when compiled with DEMUX_BCAST_EN.
module tb_demux_1_4_buf;

    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic [1:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b, c, d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`ifdef DEMUX_BCAST_EN
    logic       bcast;
`endif

    int total = 0;
    int bad   = 0;

    demux_1_4_buf #(.N(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef DEMUX_BCAST_EN
        .bcast(bcast),
`endif
        .X(x),
        .SEL(sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(a),
        .B(b),
        .C(c),
        .D(d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_A(cnt_a),
        .cnt_B(cnt_b),
        .cnt_C(cnt_c),
        .cnt_D(cnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] x;
        logic [1:0] sel;
        logic       iv;
        logic [3:0] ordy;
        logic       rdy;
        logic [3:0] ov;
        logic [3:0] ea, eb, ec, ed;
        logic [1:0] ca, cb, cc, cd;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic r, input logic [3:0] xi, input logic [1:0] s,
                                input logic iv, input logic [3:0] ordy, input logic rdy,
                                input logic [3:0] ov, input logic [3:0] ea, input logic [3:0] eb,
                                input logic [3:0] ec, input logic [3:0] ed, input logic [1:0] ca,
                                input logic [1:0] cb, input logic [1:0] cc, input logic [1:0] cd);
        vec_t v;
        v.rst = r;  v.x = xi;  v.sel = s;  v.iv = iv;  v.ordy = ordy;
        v.rdy = rdy; v.ov = ov;
        v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
        v.ca = ca; v.cb = cb; v.cc = cc; v.cd = cd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, let combinational outputs settle, then sample.
    task automatic drive(input logic r, input logic [3:0] xi, input logic [1:0] s,
                         input logic iv, input logic [3:0] ordy);
        @(negedge clk);
        rst = r; x = xi; sel = s; in_valid = iv; out_ready = ordy;
        #1;
    endtask

    // Producer-side rule: a stalled offer must be held until it is taken or withdrawn.
    logic       hold_pending = 1'b0;
    logic [3:0] held_x;
    logic [1:0] held_sel;
    always @(posedge clk) begin
        if (hold_pending && in_valid && !rst) begin
            check("stall_hold", {26'd0, sel, x}, {26'd0, held_sel, held_x});
        end
        hold_pending = in_valid && !in_ready;
        held_x       = x;
        held_sel     = sel;
    end

    initial begin
        rst = 1'b1; x = '0; sel = '0; in_valid = 1'b0; out_ready = '0;
`ifdef DEMUX_BCAST_EN
        bcast = 1'b0;
`endif
        //              rst x     sel iv ordy     | rdy ov       A     B     C     D     cA cB cC cD
        vecs[0]  = mk(1, 4'h0, 0, 0, 4'b0000,   0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 4'h0, 0, 0, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 4'hA, 1, 1, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 4'h0, 1, 0, 4'b0000,   1, 4'b0010, 4'h0, 4'hA, 4'h0, 4'h0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 4'h0, 1, 0, 4'b0010,   1, 4'b0010, 4'h0, 4'hA, 4'h0, 4'h0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 4'h3, 2, 1, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 4'h5, 2, 1, 4'b0000,   1, 4'b0100, 4'h0, 4'h0, 4'h3, 4'h0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 4'h7, 2, 1, 4'b0000,   0, 4'b0100, 4'h0, 4'h0, 4'h3, 4'h0, 0, 0, 2, 0);
        vecs[8]  = mk(0, 4'h7, 0, 0, 4'b0000,   1, 4'b0100, 4'h0, 4'h0, 4'h3, 4'h0, 0, 0, 2, 0);
        vecs[9]  = mk(0, 4'h7, 2, 1, 4'b0100,   0, 4'b0100, 4'h0, 4'h0, 4'h3, 4'h0, 0, 0, 2, 0);
        vecs[10] = mk(0, 4'h7, 2, 0, 4'b0100,   1, 4'b0100, 4'h0, 4'h0, 4'h5, 4'h0, 0, 0, 1, 0);
        vecs[11] = mk(0, 4'h0, 2, 0, 4'b0100,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[12] = mk(0, 4'h0, 2, 0, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[13] = mk(0, 4'h1, 3, 1, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[14] = mk(0, 4'h2, 3, 1, 4'b1000,   1, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 1);
        vecs[15] = mk(0, 4'h0, 3, 0, 4'b0000,   1, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0, 0, 1);
        vecs[16] = mk(0, 4'h0, 3, 0, 4'b1000,   1, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0, 0, 1);
        vecs[17] = mk(0, 4'h6, 0, 1, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[18] = mk(0, 4'h7, 0, 1, 4'b0000,   1, 4'b0001, 4'h6, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
        vecs[19] = mk(0, 4'h8, 1, 1, 4'b0000,   1, 4'b0001, 4'h6, 4'h0, 4'h0, 4'h0, 2, 0, 0, 0);
        vecs[20] = mk(1, 4'h9, 1, 1, 4'b1111,   0, 4'b0011, 4'h6, 4'h8, 4'h0, 4'h0, 2, 1, 0, 0);
        vecs[21] = mk(0, 4'h0, 0, 0, 4'b1111,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        vecs[22] = mk(0, 4'h0, 0, 0, 4'b0000,   1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].x, vecs[i].sel, vecs[i].iv, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].rdy});
            check($sformatf("v%0d out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].ov});
            check($sformatf("v%0d A", i),         {28'd0, a},         {28'd0, vecs[i].ea});
            check($sformatf("v%0d B", i),         {28'd0, b},         {28'd0, vecs[i].eb});
            check($sformatf("v%0d C", i),         {28'd0, c},         {28'd0, vecs[i].ec});
            check($sformatf("v%0d D", i),         {28'd0, d},         {28'd0, vecs[i].ed});
            check($sformatf("v%0d cnt_A", i),     {30'd0, cnt_a},     {30'd0, vecs[i].ca});
            check($sformatf("v%0d cnt_B", i),     {30'd0, cnt_b},     {30'd0, vecs[i].cb});
            check($sformatf("v%0d cnt_C", i),     {30'd0, cnt_c},     {30'd0, vecs[i].cc});
            check($sformatf("v%0d cnt_D", i),     {30'd0, cnt_d},     {30'd0, vecs[i].cd});
        end

        // Full channel A blocks only SEL=00; then pop A and B in the same cycle.
        drive(0, 4'hC, 0, 1, 4'b0000);
        drive(0, 4'hD, 0, 1, 4'b0000);
        drive(0, 4'hE, 1, 1, 4'b0000);
        for (int s = 0; s < 4; s++) begin
            drive(0, 4'h0, 2'(s), 0, 4'b0000);
            check($sformatf("indep sel%0d in_ready", s), {31'd0, in_ready}, {31'd0, (s != 0)});
        end
        check("indep cnt_A", {30'd0, cnt_a}, 32'd2);
        check("indep A head", {28'd0, a}, 32'hC);
        drive(0, 4'h0, 0, 0, 4'b0011);
        drive(0, 4'h0, 0, 0, 4'b0000);
        check("multipop out_valid", {28'd0, out_valid}, 32'b0001);
        check("multipop A", {28'd0, a}, 32'hD);
        check("multipop cnt_A", {30'd0, cnt_a}, 32'd1);
        check("multipop cnt_B", {30'd0, cnt_b}, 32'd0);
        drive(0, 4'h0, 0, 0, 4'b0001);
        drive(0, 4'h0, 0, 0, 4'b0000);
        check("drain cnt_A", {30'd0, cnt_a}, 32'd0);
        check("drain A", {28'd0, a}, 32'h0);

`ifdef DEMUX_BCAST_EN
        @(negedge clk);
        bcast = 1'b1; x = 4'hF; sel = 2'd2; in_valid = 1'b1; out_ready = '0;
        #1;
        check("bcast in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        bcast = 1'b0; x = 4'hE; sel = 2'd0; in_valid = 1'b1;
        #1;
        check("bcast out_valid", {28'd0, out_valid}, 32'b1111);
        check("bcast A", {28'd0, a}, 32'hF);
        check("bcast B", {28'd0, b}, 32'hF);
        check("bcast C", {28'd0, c}, 32'hF);
        check("bcast D", {28'd0, d}, 32'hF);
        @(negedge clk);
        bcast = 1'b1; x = 4'h9; in_valid = 1'b1;
        #1;
        check("bcast full in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        bcast = 1'b0; in_valid = 1'b0;
        #1;
        check("bcast blocked cnt_A", {30'd0, cnt_a}, 32'd2);
        check("bcast blocked cnt_B", {30'd0, cnt_b}, 32'd1);
        check("bcast blocked cnt_C", {30'd0, cnt_c}, 32'd1);
        check("bcast blocked cnt_D", {30'd0, cnt_d}, 32'd1);
        check("bcast blocked D", {28'd0, d}, 32'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
